// File: rtl/matrix_fetch_if.sv
// Memory read port between matrix_fetch and a word-addressed memory.
// Read data returns one cycle after the cycle the strobe is high.
interface matrix_fetch_if #(
  parameter int ADDR_W = 8
) ();
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;

  modport master (output mem_rd, output mem_addr, input mem_rdata);
  modport slave  (input mem_rd, input mem_addr, output mem_rdata);
endinterface

// File: rtl/matrix_fetch.sv
// Fetches a 4x4 matrix of 16-bit words (16 sequential reads) and publishes it atomically.
// Optional macro FETCH_TRANSPOSE_EN: memory holds the matrix column-major, output is row-major.
//
// state | meaning
// IDLE  | waiting for start, done=1
// READ  | issuing 16 reads, one per cycle
// LAST  | capturing the final element
// DONE  | one cycle, matrix updated, m_valid=1
module matrix_fetch #(
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  matrix_fetch_if.master       mem,
  output logic [255:0]         matrix,
  output logic                 done,
  output logic                 m_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t       state;
  logic [3:0]   idx;
  logic [3:0]   cap_idx;
  logic         rd_q;
  logic [255:0] staging;
  logic [255:0] stage_next;
  logic [3:0]   pos;

  // rd_q/cap_idx trail the read strobe by one cycle, matching the memory latency
  always_comb begin
`ifdef FETCH_TRANSPOSE_EN
    pos = {cap_idx[1:0], cap_idx[3:2]};
`else
    pos = cap_idx;
`endif
    stage_next = staging;
    if (rd_q) begin
      stage_next[{pos, 4'b0000} +: 16] = mem.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state        <= IDLE;
      idx          <= 4'd0;
      cap_idx      <= 4'd0;
      rd_q         <= 1'b0;
      staging      <= '0;
      matrix       <= '0;
      mem.mem_rd   <= 1'b0;
      mem.mem_addr <= '0;
      done         <= 1'b1;
      m_valid      <= 1'b0;
    end else begin
      rd_q    <= mem.mem_rd;
      cap_idx <= idx;
      staging <= stage_next;
      m_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= READ;
            idx          <= 4'd0;
            mem.mem_rd   <= 1'b1;
            mem.mem_addr <= base_addr;
            done         <= 1'b0;
          end
        end
        READ: begin
          if (idx == 4'd15) begin
            state      <= LAST;
            mem.mem_rd <= 1'b0;
          end else begin
            idx          <= idx + 4'd1;
            mem.mem_addr <= mem.mem_addr + ADDR_ONE;
          end
        end
        LAST: begin
          // the final element is merged straight into the published copy
          state   <= DONE;
          matrix  <= stage_next;
          m_valid <= 1'b1;
          done    <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          mem.mem_rd <= 1'b0;
          done       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_fetch.sv
// Directed bench for matrix_fetch: table of element checks plus reset/abort and back-to-back sequences.
module tb_matrix_fetch;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   base_addr = 8'h00;
  logic [255:0] matrix;
  logic         done;
  logic         m_valid;

  matrix_fetch_if #(.ADDR_W(8)) bus ();

  matrix_fetch #(.ADDR_W(8)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .start     (start),
    .base_addr (base_addr),
    .mem       (bus),
    .matrix    (matrix),
    .done      (done),
    .m_valid   (m_valid)
  );

  always #5 clk = ~clk;

  logic [15:0] mem_arr [256];

  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= mem_arr[bus.mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  base;
    logic [15:0] val;
    int          lo_def;
    int          lo_tr;
  } vec_t;

  vec_t vecs [8];

  // One fetch from base b; optionally pulses start at negedge pulse_j (ignored by DUT).
  task automatic run_fetch(input logic [7:0] b, input int pulse_j);
    int nrd;
    int mv_edge;
    int nmv;
    int partial;
    logic [255:0] prev;
    nrd = 0; mv_edge = -1; nmv = 0; partial = 0;
    @(negedge clk);
    base_addr = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    prev = matrix;
    for (int j = 0; j <= 20; j++) begin
      @(negedge clk);
      if (bus.mem_rd) begin
        chk("rd_addr", 256'(bus.mem_addr), 256'(8'(b + 8'(nrd))));
        nrd++;
      end
      if (m_valid) begin
        nmv++;
        if (mv_edge < 0) mv_edge = j;
      end
      if (j < 17 && matrix !== prev) partial = 1;
      if (j == 8) chk("done_busy", 256'(done), 256'(1'b0));
      if (j == 17) chk("done_final", 256'(done), 256'(1'b1));
      start = (j == pulse_j) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    chk("rd_count", 256'(nrd), 256'(16));
    chk("mvalid_edge", 256'(mv_edge), 256'(17));
    chk("mvalid_count", 256'(nmv), 256'(1));
    chk("atomic_update", 256'(partial), 256'(0));
  endtask

  initial begin
    int lo;
    int nmv;
    int nrd;
    int mv_first;
    int mv_second;
    logic rd18;
    logic rd19;

    for (int a = 0; a < 256; a++) mem_arr[a] = 16'(16'h0100 + a - 16'h0010);

    vecs[0] = '{8'h10, 16'h0100,   0,   0};
    vecs[1] = '{8'h10, 16'h010F, 240, 240};
    vecs[2] = '{8'h10, 16'h0101,  16,  64};
    vecs[3] = '{8'h10, 16'h0104,  64,  16};
    vecs[4] = '{8'hFC, 16'h00F0,  64,  16};
    vecs[5] = '{8'hFC, 16'h01EC,   0,   0};
    vecs[6] = '{8'hFC, 16'h00FB, 240, 240};
    vecs[7] = '{8'hFC, 16'h00F2,  96, 144};

    // reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_matrix", matrix, 256'(0));
    chk("rst_done", 256'(done), 256'(1'b1));
    chk("rst_mvalid", 256'(m_valid), 256'(1'b0));
    chk("rst_mem_rd", 256'(bus.mem_rd), 256'(1'b0));
    chk("rst_mem_addr", 256'(bus.mem_addr), 256'(8'h00));

    // element placement table (address wrap covered by the 0xFC rows)
    for (int i = 0; i < 8; i++) begin
      run_fetch(vecs[i].base, -1);
`ifdef FETCH_TRANSPOSE_EN
      lo = vecs[i].lo_tr;
`else
      lo = vecs[i].lo_def;
`endif
      chk($sformatf("elem_%0d", i), 256'(matrix[lo +: 16]), 256'(vecs[i].val));
    end

    // start pulsed mid-READ must not queue a second fetch
    run_fetch(8'h10, 4);
    nrd = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.mem_rd) nrd++;
    end
    chk("no_queued_start", 256'(nrd), 256'(0));

    // reset at E8 of a second fetch with start high on the reset edge
    @(negedge clk);
    base_addr = 8'h10;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int j = 0; j <= 7; j++) @(negedge clk);
    nreset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("abort_matrix", matrix, 256'(0));
    chk("abort_done", 256'(done), 256'(1'b1));
    chk("abort_mvalid", 256'(m_valid), 256'(1'b0));
    chk("abort_mem_rd", 256'(bus.mem_rd), 256'(1'b0));
    nreset = 1'b1;
    start = 1'b0;
    nmv = 0;
    nrd = 0;
    repeat (25) begin
      @(negedge clk);
      if (m_valid) nmv++;
      if (bus.mem_rd) nrd++;
    end
    chk("abort_no_mvalid", 256'(nmv), 256'(0));
    chk("abort_no_restart", 256'(nrd), 256'(0));
    chk("abort_done_idle", 256'(done), 256'(1'b1));

    // start held high: DONE, one IDLE cycle, then the next READ
    mv_first = -1; mv_second = -1; nmv = 0; rd18 = 1'bx; rd19 = 1'bx;
    @(negedge clk);
    base_addr = 8'h20;
    start = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= 40; j++) begin
      @(negedge clk);
      if (m_valid) begin
        nmv++;
        if (mv_first < 0) mv_first = j;
        else if (mv_second < 0) mv_second = j;
      end
      if (j == 18) rd18 = bus.mem_rd;
      if (j == 19) rd19 = bus.mem_rd;
    end
    start = 1'b0;
    chk("held_mv_first", 256'(mv_first), 256'(17));
    chk("held_mv_second", 256'(mv_second), 256'(36));
    chk("held_mv_pulses", 256'(nmv), 256'(2));
    chk("held_idle_gap", 256'(rd18), 256'(1'b0));
    chk("held_restart", 256'(rd19), 256'(1'b1));
`ifdef FETCH_TRANSPOSE_EN
    chk("held_elem1", 256'(matrix[79:64]), 256'(16'h0111));
`else
    chk("held_elem1", 256'(matrix[31:16]), 256'(16'h0111));
`endif
    repeat (30) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_fetch.md
MATRIX_FETCH -- requirements
Module: matrix_fetch

Interface
REQ-001 Parameter: ADDR_W, 8, memory word-address width.
REQ-002 Port: clk  in  1  sole clock; all logic on rising edge.
REQ-003 Port: nreset  in  1  reset, synchronous and active-low.
REQ-004 Port: start  in  1  request to fetch one 4x4 matrix; sampled only in IDLE.
REQ-005 Port: base_addr  in  ADDR_W  word address of element 0; latched on accepted start.
REQ-006 Port: mem_rd  out  1  registered read strobe, one word per cycle.
REQ-007 Port: mem_addr  out  ADDR_W  registered read address.
REQ-008 Port: mem_rdata  in  16  read data, valid the cycle after the cycle mem_rd is high.
REQ-009 Port: matrix  out  256  assembled matrix; element [row][col] at bits col*16+row*64+15 down to col*16+row*64.
REQ-010 Port: done  out  1  high when idle or complete, low while a fetch is in progress.
REQ-011 Port: m_valid  out  1  one-cycle pulse when matrix holds a newly fetched result.

Function
REQ-012 FSM states SHALL be IDLE, READ, LAST, DONE; an illegal encoding returns to IDLE.
REQ-013 IDLE: start=1 at edge E0 -> READ; base latched; idx=0; mem_rd=1; mem_addr=base_addr; done=0.
REQ-014 READ: each edge increments idx and mem_addr; at the edge where idx=15 -> LAST, mem_rd=0.
REQ-015 Element k is read from address (base+k) mod 2^ADDR_W; address wrap past all-ones is legal and silent.
REQ-016 Element k is captured from mem_rdata into a 256-bit staging buffer at edge E(k+2), k=0..15.
REQ-017 LAST: captures element 15, then -> DONE at E17.
REQ-018 DONE: lasts exactly one cycle; staging buffer is copied to matrix at E17, so matrix changes atomically and never shows a partial fetch.
REQ-019 DONE: m_valid=1 and done=1 for that single cycle; next edge -> IDLE.
REQ-020 Default packing: element k occupies matrix bits k*16+15 down to k*16, i.e. row=k/4, col=k%4 (row-major).
REQ-021 start in READ, LAST or DONE SHALL be ignored; no queuing.
REQ-022 matrix SHALL hold its value between fetches.
REQ-023 Data values are passed unmodified: no sign extension or arithmetic.

Reset
REQ-024 nreset=0 at an edge forces IDLE, mem_rd=0, mem_addr=0, idx=0, matrix=0, staging=0, done=1, m_valid=0.
REQ-025 Reset during a fetch SHALL abort it: no m_valid pulse, matrix cleared to 0; start is ignored on the reset edge.

Configuration
REQ-026 Macro FETCH_TRANSPOSE_EN defined: element k is stored at row=k%4, col=k/4 (bits (k/4)*16+(k%4)*64+15 downto same); memory holds the matrix column-major and the output is transposed to row-major.
REQ-027 Macro undefined: REQ-020 packing applies and no transpose logic is built; timing is identical either way.

Verification
REQ-028 Reset, then idle -> matrix=0, done=1, m_valid=0, mem_rd=0.
REQ-029 Memory[0x10+k]=0x0100+k, start with base=0x10 -> mem_rd high for 16 cycles on 0x10..0x1F; m_valid 17 edges after start; matrix[15:0]=0x0100, matrix[255:240]=0x010F.
REQ-030 base=0xFC, ADDR_W=8 -> addresses 0xFC..0xFF, then 0x00..0x0B; element 4 read from 0x00.
REQ-031 With FETCH_TRANSPOSE_EN, same data as REQ-029 -> matrix[79:64]=0x0101 and matrix[31:16]=0x0104.
REQ-032 start pulsed during READ, then reset at E8 of a second fetch -> the extra start has no effect; after reset, matrix=0, no m_valid pulse, done=1.
REQ-033 start held high continuously -> fetches repeat with one IDLE cycle between DONE and the next READ; each m_valid is exactly one cycle.
